// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into sensor instructions (mode, address, 0-2 data bytes)
// and writes each completed frame into the arbiter's four aligned queue buffers.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        buffers_full,
  output logic        wr_addrbuffer,
  output logic        wr_opbuffer,
  output logic        wr_databuffer1,
  output logic        wr_databuffer2,
  output logic [7:0]  addr_pointer,
  output logic [15:0] wr_data,
  output logic [7:0]  mode,
  output logic        busy,
  output logic        cmd_dropped,
  output logic        err_bad_mode,
  output logic        err_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA_HI, DATA_LO} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [7:0]    addr_q;
  logic [7:0]    hi_q;
  logic [CW-1:0] tcount;
  logic          wr_strobe;

  logic          frame_done;
  logic [7:0]    done_addr;
  logic [15:0]   done_data;
  logic          timed_out;

  // One shared strobe register keeps the four queue writes in lockstep.
  assign wr_addrbuffer  = wr_strobe;
  assign wr_opbuffer    = wr_strobe;
  assign wr_databuffer1 = wr_strobe;
  assign wr_databuffer2 = wr_strobe;

  always_comb begin
    frame_done = 1'b0;
    done_addr  = addr_q;
    done_data  = 16'h0000;
    timed_out  = (state != IDLE) && !rx_valid && (tcount == CW'(TIMEOUT_CYCLES - 1));
    if (rx_valid) begin
      if (state == ADDR && !op_q[1]) begin
        frame_done = 1'b1;
        done_addr  = rx_data;
      end else if (state == DATA_LO) begin
        frame_done = 1'b1;
        done_data  = {(op_q[0] ? hi_q : 8'h00), rx_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= 2'd0;
      addr_q       <= 8'h00;
      hi_q         <= 8'h00;
      tcount       <= '0;
      wr_strobe    <= 1'b0;
      addr_pointer <= 8'h00;
      wr_data      <= 16'h0000;
      mode         <= 8'h00;
      busy         <= 1'b0;
      cmd_dropped  <= 1'b0;
      err_bad_mode <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      wr_strobe    <= 1'b0;
      cmd_dropped  <= 1'b0;
      err_bad_mode <= 1'b0;
      err_timeout  <= 1'b0;

      if (timed_out) begin
        state       <= IDLE;
        busy        <= 1'b0;
        tcount      <= '0;
        err_timeout <= 1'b1;
      end else begin
        if (state != IDLE) tcount <= tcount + 1'b1;
        if (rx_valid) begin
          tcount <= '0;
          case (state)
            IDLE: begin
              if (rx_data[7:2] == 6'd0) begin
                op_q  <= rx_data[1:0];
                state <= ADDR;
                busy  <= 1'b1;
              end else begin
                err_bad_mode <= 1'b1;
              end
            end
            ADDR: begin
              addr_q <= rx_data;
              if (!op_q[1]) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (op_q[0]) begin
                state <= DATA_HI;
              end else begin
                state <= DATA_LO;
              end
            end
            DATA_HI: begin
              hi_q  <= rx_data;
              state <= DATA_LO;
            end
            DATA_LO: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
            default: state <= IDLE;
          endcase
        end
      end

      // Output fields only change on a real queue write, so they hold between writes.
      if (frame_done) begin
        if (!buffers_full) begin
          wr_strobe    <= 1'b1;
          addr_pointer <= done_addr;
          wr_data      <= done_data;
          mode         <= {6'b0, op_q};
        end else begin
          cmd_dropped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: frame decoding, errors, timeout, drop and reset.
module tb_uart_cmd_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        buffers_full;
  logic        wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2;
  logic [7:0]  addr_pointer;
  logic [15:0] wr_data;
  logic [7:0]  mode;
  logic        busy, cmd_dropped, err_bad_mode, err_timeout;

  int checks = 0;
  int errors = 0;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .buffers_full(buffers_full),
    .wr_addrbuffer(wr_addrbuffer),
    .wr_opbuffer(wr_opbuffer),
    .wr_databuffer1(wr_databuffer1),
    .wr_databuffer2(wr_databuffer2),
    .addr_pointer(addr_pointer),
    .wr_data(wr_data),
    .mode(mode),
    .busy(busy),
    .cmd_dropped(cmd_dropped),
    .err_bad_mode(err_bad_mode),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] strobes();
    return {wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Presents one byte for a single clock, then samples just after the edge.
  task automatic applyStimulus(input logic [7:0] b, input logic full);
    @(negedge clk);
    rx_data      = b;
    rx_valid     = 1'b1;
    buffers_full = full;
    @(posedge clk);
    #1;
    rx_valid     = 1'b0;
    buffers_full = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_strobes"}, 32'(strobes()), 32'h0);
    checkOutput({tag, "_addr"}, 32'(addr_pointer), 32'h0);
    checkOutput({tag, "_data"}, 32'(wr_data), 32'h0);
    checkOutput({tag, "_mode"}, 32'(mode), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_flags"}, 32'({cmd_dropped, err_bad_mode, err_timeout}), 32'h0);
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] m, input logic [7:0] a, input logic [15:0] d);
    checkOutput({tag, "_strobes"}, 32'(strobes()), 32'hF);
    checkOutput({tag, "_mode"}, 32'(mode), 32'(m));
    checkOutput({tag, "_addr"}, 32'(addr_pointer), 32'(a));
    checkOutput({tag, "_data"}, 32'(wr_data), 32'(d));
  endtask

  initial begin
    reset        = 1'b1;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    buffers_full = 1'b0;
    idleCycles(2);
    checkIdleOutputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Read 2 bytes: shortest frame
    applyStimulus(8'h01, 1'b0);
    checkOutput("rd_busy_mid", 32'(busy), 32'h1);
    checkOutput("rd_no_strobe_mid", 32'(strobes()), 32'h0);
    applyStimulus(8'h00, 1'b0);
    checkWrite("rd", 8'h01, 8'h00, 16'h0000);
    checkOutput("rd_busy_after", 32'(busy), 32'h0);
    idleCycles(1);
    checkOutput("rd_strobe_one_cycle", 32'(strobes()), 32'h0);

    // Write 2 bytes, MSB first
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'hAB, 1'b0);
    checkOutput("wr2_no_strobe_early", 32'(strobes()), 32'h0);
    applyStimulus(8'hCD, 1'b0);
    checkWrite("wr2", 8'h03, 8'h02, 16'hABCD);
    idleCycles(1);
    checkOutput("wr2_strobe_off", 32'(strobes()), 32'h0);
    checkOutput("wr2_data_hold", 32'(wr_data), 32'hABCD);

    // Write 1 byte
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    checkWrite("wr1", 8'h02, 8'h01, 16'h005A);

    // Illegal mode, then a normal frame
    applyStimulus(8'h84, 1'b0);
    checkOutput("bad_mode_pulse", 32'(err_bad_mode), 32'h1);
    checkOutput("bad_mode_busy", 32'(busy), 32'h0);
    checkOutput("bad_mode_strobes", 32'(strobes()), 32'h0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("bad_mode_clear", 32'(err_bad_mode), 32'h0);
    checkOutput("bad_mode_next_busy", 32'(busy), 32'h1);
    applyStimulus(8'h05, 1'b0);
    checkWrite("after_bad", 8'h00, 8'h05, 16'h0000);

    // Silence after address: timeout on the 10th idle cycle
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h02, 1'b0);
    idleCycles(9);
    checkOutput("to_not_yet", 32'(err_timeout), 32'h0);
    checkOutput("to_busy_before", 32'(busy), 32'h1);
    idleCycles(1);
    checkOutput("to_pulse", 32'(err_timeout), 32'h1);
    checkOutput("to_busy_drop", 32'(busy), 32'h0);
    checkOutput("to_strobes", 32'(strobes()), 32'h0);
    idleCycles(1);
    checkOutput("to_pulse_end", 32'(err_timeout), 32'h0);

    // Byte on exactly the 10th idle cycle is accepted
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h02, 1'b0);
    idleCycles(9);
    applyStimulus(8'h11, 1'b0);
    checkOutput("edge_no_timeout", 32'(err_timeout), 32'h0);
    checkOutput("edge_busy", 32'(busy), 32'h1);
    applyStimulus(8'h22, 1'b0);
    checkWrite("edge_write", 8'h03, 8'h02, 16'h1122);

    // Queue full at completion drops the frame
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b1);
    checkOutput("drop_pulse", 32'(cmd_dropped), 32'h1);
    checkOutput("drop_strobes", 32'(strobes()), 32'h0);
    checkOutput("drop_busy", 32'(busy), 32'h0);
    checkOutput("drop_addr_hold", 32'(addr_pointer), 32'h02);
    idleCycles(1);
    checkOutput("drop_pulse_end", 32'(cmd_dropped), 32'h0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h07, 1'b0);
    checkWrite("after_drop", 8'h00, 8'h07, 16'h0000);

    // Back-to-back: mode byte during the strobe cycle
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h09, 1'b0);
    checkWrite("b2b_first", 8'h01, 8'h09, 16'h0000);
    applyStimulus(8'h01, 1'b0);
    checkOutput("b2b_busy", 32'(busy), 32'h1);
    applyStimulus(8'h0A, 1'b0);
    checkWrite("b2b_second", 8'h01, 8'h0A, 16'h0000);

    // Reset mid-frame discards the partial frame
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    pulseReset();
    checkIdleOutputs("midreset");
    applyStimulus(8'hEE, 1'b0);
    checkOutput("midreset_no_ghost", 32'(strobes()), 32'h0);
    checkOutput("midreset_ee_bad", 32'(err_bad_mode), 32'h1);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkWrite("post_reset", 8'h01, 8'h00, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
